// File: rtl/mcpu_pkg.sv
// Shared pipeline definitions for the writeback-side forwarding logic:
// back-bus layout, MEM-stage FSM states and the pipeline-entry record.
package mcpu_pkg;

   localparam int BACK_W      = 38;
   localparam int BACK_RW_BIT = 37;
   localparam int BACK_WD_LSB = 5;
   localparam int BACK_RD_LSB = 0;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic        valid;
      logic        regWrite;
      logic        isLoad;
      logic [4:0]  rd;
      logic [31:0] data;
   } pipe_entry_t;

   // Back bus: {regWrite, Wd, rd}; invalid entries never advertise a write.
   function automatic logic [BACK_W-1:0] pack_back(input pipe_entry_t e);
      logic [BACK_W-1:0] b;
      b = '0;
      b[BACK_RW_BIT]                   = e.valid & e.regWrite;
      b[BACK_RW_BIT-1:BACK_WD_LSB]     = e.data;
      b[BACK_WD_LSB-1:BACK_RD_LSB]     = e.rd;
      return b;
   endfunction

endpackage

// File: rtl/back_bus_gen_load_use_detect.sv
// Combinational load-use hazard term: a load in EX whose destination feeds
// either source operand of the instruction currently in ID.
module load_use_detect (
   input  logic       ex_valid,
   input  logic       ex_isLoad,
   input  logic       ex_regWrite,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   output logic       load_use
);

   logic w_rd_nz;
   logic w_hit;

   assign w_rd_nz  = (ex_rd != 5'd0);
   assign w_hit    = (ex_rd == id_rs) | (ex_rd == id_rt);
   assign load_use = ex_valid & ex_isLoad & ex_regWrite & w_rd_nz & w_hit;

endmodule

// File: rtl/back_bus_gen.sv
// MEM/WB pipeline registers, MEM_BACK/WB_BACK forwarding buses, register-file
// write port and STALL. Define LOAD_USE_STALL_EN to fold load-use into STALL.
module back_bus_gen
   import mcpu_pkg::*;
#(
   parameter int BACK_W = 38,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_regWrite,
   input  logic              ex_isLoad,
   input  logic [4:0]        ex_rd,
   input  logic [XLEN-1:0]   ex_alu,
   input  logic              ex_flush,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_ready,
   output logic [BACK_W-1:0] MEM_BACK,
   output logic              USE_MEM_BACK,
   output logic [BACK_W-1:0] WB_BACK,
   output logic              USE_WB_BACK,
   output logic              STALL,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [XLEN-1:0]   rf_wdata
);

   pipe_entry_t r_mem;
   pipe_entry_t r_wb;
   mem_state_t  r_state;
   logic        w_mem_wait;
   logic        w_load_use;
   logic        w_unused_wb;

   assign w_mem_wait = r_mem.valid & r_mem.isLoad & ~dmem_ready;

`ifdef LOAD_USE_STALL_EN
   load_use_detect u_load_use_detect (
      .ex_valid    (ex_valid),
      .ex_isLoad   (ex_isLoad),
      .ex_regWrite (ex_regWrite),
      .ex_rd       (ex_rd),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .load_use    (w_load_use)
   );
`else
   // Load-use detection lives in an external hazard unit in this build.
   logic w_unused_id;
   assign w_load_use  = 1'b0;
   assign w_unused_id = ^{id_rs, id_rt};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
         r_mem   <= '0;
         r_wb    <= '0;
      end else begin
         case (r_state)
            RUN:  if (w_mem_wait) r_state <= WAIT;
            WAIT: if (dmem_ready) r_state <= RUN;
         endcase
         if (w_mem_wait) begin
            // Load still outstanding: MEM and EX hold, WB takes a bubble.
            r_wb <= '0;
         end else begin
            r_wb.valid    <= r_mem.valid;
            r_wb.regWrite <= r_mem.regWrite;
            r_wb.isLoad   <= 1'b0;
            r_wb.rd       <= r_mem.rd;
            r_wb.data     <= r_mem.isLoad ? dmem_rdata : r_mem.data;
            r_mem.valid    <= ex_valid & ~ex_flush;
            r_mem.regWrite <= ex_regWrite;
            r_mem.isLoad   <= ex_isLoad;
            r_mem.rd       <= ex_rd;
            r_mem.data     <= ex_alu;
         end
      end
   end

   assign w_unused_wb  = r_wb.isLoad;

   assign MEM_BACK     = pack_back(r_mem);
   assign USE_MEM_BACK = r_mem.valid & ~r_mem.isLoad;
   assign WB_BACK      = pack_back(r_wb);
   assign USE_WB_BACK  = r_wb.valid;
   assign STALL        = w_mem_wait | w_load_use;

   assign rf_we        = r_wb.valid & r_wb.regWrite & (r_wb.rd != 5'd0);
   assign rf_waddr     = r_wb.rd;
   assign rf_wdata     = r_wb.data;

endmodule

// File: tb/tb_back_bus_gen.sv
// Self-checking bench for back_bus_gen: per-cycle vector table plus an
// register-file write scoreboard, and a reset-during-WAIT sequence.
module tb_back_bus_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 0, ex_regWrite = 0, ex_isLoad = 0, ex_flush = 0;
   logic [4:0]  ex_rd = 0, id_rs = 0, id_rt = 0;
   logic [31:0] ex_alu = 0, dmem_rdata = 0;
   logic        dmem_ready = 0;
   logic [37:0] MEM_BACK, WB_BACK;
   logic        USE_MEM_BACK, USE_WB_BACK, STALL, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   back_bus_gen dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_isLoad(ex_isLoad),
      .ex_rd(ex_rd), .ex_alu(ex_alu), .ex_flush(ex_flush),
      .id_rs(id_rs), .id_rt(id_rt),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .MEM_BACK(MEM_BACK), .USE_MEM_BACK(USE_MEM_BACK),
      .WB_BACK(WB_BACK), .USE_WB_BACK(USE_WB_BACK),
      .STALL(STALL), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

`ifdef LOAD_USE_STALL_EN
   localparam logic LU = 1'b1;
`else
   localparam logic LU = 1'b0;
`endif

   localparam logic [37:0] F = {38{1'b1}};
   localparam logic [37:0] R = 38'h20_0000_0000;

   typedef struct {
      logic v, rw, ld; logic [4:0] rd; logic [31:0] alu; logic fl;
      logic [4:0] rs, rt; logic [31:0] rdata; logic rdy;
      logic [37:0] mb, mbm; logic umb;
      logic [37:0] wb, wbm; logic uwb, stall, we;
      logic push; logic [31:0] sbd;
   } vec_t;

   vec_t        vecs[15];
   logic [36:0] sb_q[$];
   int          n_chk = 0;
   int          n_pass = 0;

   function automatic logic [37:0] B(input logic rw, input logic [31:0] d, input logic [4:0] rd);
      return {rw, d, rd};
   endfunction

   task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] exp, input logic [37:0] msk);
      n_chk++;
      if ((act & msk) === (exp & msk)) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act & msk, exp & msk);
   endtask

   task automatic sb_check(input string nm);
      logic [36:0] e;
      if (rf_we) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s_sb: unexpected rf write addr %0d data %h", nm, rf_waddr, rf_wdata);
         end else begin
            e = sb_q.pop_front();
            chk({nm, "_rfwrite"}, {1'b0, rf_waddr, rf_wdata}, {1'b0, e}, F);
         end
      end
   endtask

   task automatic drive(input vec_t t);
      ex_valid = t.v; ex_regWrite = t.rw; ex_isLoad = t.ld; ex_rd = t.rd;
      ex_alu = t.alu; ex_flush = t.fl; id_rs = t.rs; id_rt = t.rt;
      dmem_rdata = t.rdata; dmem_ready = t.rdy;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_mb"}, MEM_BACK, '0, F);
      chk({nm, "_wb"}, WB_BACK, '0, F);
      chk({nm, "_use"}, {36'd0, USE_MEM_BACK, USE_WB_BACK}, '0, F);
      chk({nm, "_stall"}, {37'd0, STALL}, '0, F);
      chk({nm, "_we"}, {37'd0, rf_we}, '0, F);
   endtask

   initial begin
      //          v  rw ld rd  alu           fl rs rt rdata         rdy  mb                        mbm umb wb                          wbm uwb stall we push sbd
      vecs[0]  = '{1, 1, 0, 5,  32'h1234,     0, 0, 0, 32'h0,        0,   '0,                        F,  0,  '0,                         F,  0,  0,    0, 1,  32'h1234};
      vecs[1]  = '{1, 1, 1, 8,  32'h100,      0, 0, 0, 32'h0,        0,   B(1, 32'h1234, 5),         F,  1,  '0,                         F,  0,  0,    0, 1,  32'hDEADBEEF};
      vecs[2]  = '{0, 0, 0, 0,  32'h0,        0, 0, 0, 32'hDEADBEEF, 1,   B(1, 32'h100, 8),          F,  0,  B(1, 32'h1234, 5),          F,  1,  0,    1, 0,  32'h0};
      vecs[3]  = '{1, 1, 1, 9,  32'h200,      0, 0, 0, 32'h0,        0,   '0,                        F,  0,  B(1, 32'hDEADBEEF, 8),      F,  1,  0,    1, 1,  32'hCAFEF00D};
      vecs[4]  = '{1, 1, 0, 10, 32'h55,       0, 0, 0, 32'h0,        0,   B(1, 32'h200, 9),          F,  0,  '0,                         R,  0,  1,    0, 0,  32'h0};
      vecs[5]  = '{1, 1, 0, 10, 32'h55,       0, 0, 0, 32'h0,        0,   B(1, 32'h200, 9),          F,  0,  '0,                         R,  0,  1,    0, 0,  32'h0};
      vecs[6]  = '{1, 1, 0, 10, 32'h55,       0, 0, 0, 32'h0,        0,   B(1, 32'h200, 9),          F,  0,  '0,                         R,  0,  1,    0, 0,  32'h0};
      vecs[7]  = '{1, 1, 0, 10, 32'h55,       0, 0, 0, 32'hCAFEF00D, 1,   B(1, 32'h200, 9),          F,  0,  '0,                         R,  0,  0,    0, 1,  32'h55};
      vecs[8]  = '{0, 0, 0, 0,  32'h0,        0, 0, 0, 32'h0,        0,   B(1, 32'h55, 10),          F,  1,  B(1, 32'hCAFEF00D, 9),      F,  1,  0,    1, 0,  32'h0};
      vecs[9]  = '{1, 1, 1, 4,  32'h300,      0, 0, 4, 32'h0,        0,   '0,                        F,  0,  B(1, 32'h55, 10),           F,  1,  LU,   1, 1,  32'h4444};
      vecs[10] = '{0, 0, 0, 0,  32'h0,        0, 0, 4, 32'h4444,     1,   B(1, 32'h300, 4),          F,  0,  '0,                         R,  0,  0,    0, 0,  32'h0};
      vecs[11] = '{1, 1, 0, 0,  32'h99,       0, 0, 0, 32'h0,        0,   '0,                        F,  0,  B(1, 32'h4444, 4),          F,  1,  0,    1, 0,  32'h0};
      vecs[12] = '{1, 1, 0, 6,  32'h66,       1, 0, 0, 32'h0,        0,   B(1, 32'h99, 0),           F,  1,  '0,                         R,  0,  0,    0, 0,  32'h0};
      vecs[13] = '{0, 0, 0, 0,  32'h0,        0, 0, 0, 32'h0,        0,   B(0, 32'h66, 6),           R,  0,  B(1, 32'h99, 0),            F,  1,  0,    0, 0,  32'h0};
      vecs[14] = '{0, 0, 0, 0,  32'h0,        0, 0, 0, 32'h0,        0,   '0,                        F,  0,  '0,                         R,  0,  0,    0, 0,  32'h0};

      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         if (vecs[i].push) sb_q.push_back({vecs[i].rd, vecs[i].sbd});
         #1;
         chk($sformatf("c%0d_mem_back", i), MEM_BACK, vecs[i].mb, vecs[i].mbm);
         chk($sformatf("c%0d_use_mem", i), {37'd0, USE_MEM_BACK}, {37'd0, vecs[i].umb}, F);
         chk($sformatf("c%0d_wb_back", i), WB_BACK, vecs[i].wb, vecs[i].wbm);
         chk($sformatf("c%0d_use_wb", i), {37'd0, USE_WB_BACK}, {37'd0, vecs[i].uwb}, F);
         chk($sformatf("c%0d_stall", i), {37'd0, STALL}, {37'd0, vecs[i].stall}, F);
         chk($sformatf("c%0d_rf_we", i), {37'd0, rf_we}, {37'd0, vecs[i].we}, F);
         sb_check($sformatf("c%0d", i));
      end

      // Reset arriving while a load is stalled in MEM.
      @(negedge clk);
      ex_valid = 1; ex_regWrite = 1; ex_isLoad = 1; ex_rd = 5'd7; ex_alu = 32'h700;
      ex_flush = 0; id_rs = 0; id_rt = 0; dmem_ready = 0; dmem_rdata = 32'h0;
      @(negedge clk);
      ex_valid = 0; ex_regWrite = 0; ex_isLoad = 0; ex_rd = 0; ex_alu = 0;
      #1;
      chk("wait_mem_back", MEM_BACK, B(1, 32'h700, 7), F);
      chk("wait_stall", {37'd0, STALL}, 38'd1, F);
      #1 rst = 1'b1;
      #1;
      chk_all_zero("rst_in_wait");
      @(negedge clk);
      rst = 1'b0;
      dmem_ready = 1'b1; dmem_rdata = 32'h7777;
      @(posedge clk);
      #1;
      chk("late_ready_use_wb", {37'd0, USE_WB_BACK}, 38'd0, F);
      chk("late_ready_rf_we", {37'd0, rf_we}, 38'd0, F);
      chk("late_ready_mem_back", MEM_BACK, '0, F);

      chk("sb_drained", {6'd0, sb_q.size()}, 38'd0, F);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
